bitonic_sort_seq: RTL and testbench

Sequential, parametrised bitonic sorter for the PSI datapath. It accepts a K-element array of W-bit keys through a valid/ready handshake and sorts it in place with K/2 shared compare-swap lanes, one network stage per clock. It then presents the sorted array with per-element duplicate flags through a second valid/ready handshake. It replaces the fully unrolled combinational sorter where gate count matters more than latency, and adds per-job direction, signed mode, and duplicate detection for set intersection.

---
 rtl/bitonic_sort_seq.sv | 137 +++++++++++++
 tb/tb_bitonic_sort_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: K/2 shared compare-swap lanes, one network stage per clock,
// valid/ready on both sides, per-job direction, optional signed keys and duplicate flags.
module bitonic_sort_seq #(
   parameter int W      = 8,
   parameter int K      = 8,
   parameter int SIGNED = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_dir,
   input  logic [W*K-1:0] in_array,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W*K-1:0] out_array,
   output logic [K-1:0]   out_dup,
   output logic           busy
);

   localparam int L  = $clog2(K);
   localparam int S  = L * (L + 1) / 2;
   localparam int CW = (S > 0) ? $clog2(S + 1) : 1;
   localparam int IW = (K > 1) ? L : 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never drops without that transfer, and the payload is stable while valid waits.
   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                state_q;
   logic [K-1:0][W-1:0]   data_q, data_d;
   logic                  dir_q;
   logic [CW-1:0]         p_q, q_q;
   logic                  in_ready_q, out_valid_q, busy_q;

   function automatic logic key_gt(input logic [W-1:0] a, input logic [W-1:0] b);
      if (SIGNED != 0) key_gt = $signed(a) > $signed(b);
      else             key_gt = a > b;
   endfunction

   generate
      if (K > 1) begin : g_net
         logic [31:0] lo_v, hi_v;
         logic        up_v;
         // Pairs of one stage are disjoint, so every lane reads data_q and writes data_d.
         always_comb begin
            data_d = data_q;
            lo_v   = '0;
            hi_v   = '0;
            up_v   = 1'b0;
            for (int i = 0; i < K; i++) begin
               lo_v = 32'(i);
               hi_v = lo_v + (32'd1 << q_q);
               if (!lo_v[q_q] && hi_v < 32'(K)) begin
                  up_v = dir_q ^ lo_v[p_q];
                  if (up_v ? key_gt(data_q[lo_v[IW-1:0]], data_q[hi_v[IW-1:0]])
                           : key_gt(data_q[hi_v[IW-1:0]], data_q[lo_v[IW-1:0]])) begin
                     data_d[lo_v[IW-1:0]] = data_q[hi_v[IW-1:0]];
                     data_d[hi_v[IW-1:0]] = data_q[lo_v[IW-1:0]];
                  end
               end
            end
         end
      end else begin : g_single
         assign data_d = data_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         dir_q       <= 1'b1;
         p_q         <= '0;
         q_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q     <= in_array;
                  dir_q      <= in_dir;
                  p_q        <= CW'(1);
                  q_q        <= '0;
                  in_ready_q <= 1'b0;
                  if (K == 1) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= SORT;
                     busy_q  <= 1'b1;
                  end
               end
            end
            SORT: begin
               data_q <= data_d;
               // q counts p-1 down to 0 inside each merge phase p.
               if (q_q == '0) begin
                  if (p_q == CW'(L)) begin
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     p_q <= p_q + 1'b1;
                     q_q <= p_q;
                  end
               end else begin
                  q_q <= q_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_dup = '0;
      for (int i = 1; i < K; i++) begin
         out_dup[i] = out_valid_q && (data_q[i] == data_q[i-1]);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_array = data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Bench for bitonic_sort_seq: five instances (K=8, K=4 signed/unsigned, K=1, K=2) driven
// through one selectable port set and checked against a plain sort-and-compare model.
module tb_bitonic_sort_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int   sel = 0;
   logic g_valid = 1'b0, g_ready = 1'b0, g_dir = 1'b1;
   logic [31:0] g_array = '0;

   logic        g_in_ready, g_out_valid, g_busy;
   logic [31:0] g_out_array;
   logic [7:0]  g_out_dup;

   logic [4:0]  iv, ordy, ir, ov, bz;
   logic [31:0] oa0;
   logic [15:0] oa1, oa4;
   logic [3:0]  oa2;
   logic [7:0]  oa3;
   logic [7:0]  od0;
   logic [3:0]  od1, od4;
   logic [0:0]  od2;
   logic [1:0]  od3;

   assign iv   = g_valid ? (5'b1 << sel) : 5'b0;
   assign ordy = g_ready ? (5'b1 << sel) : 5'b0;

   bitonic_sort_seq #(.W(4), .K(8), .SIGNED(0)) u_k8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_dir(g_dir),
      .in_array(g_array), .out_valid(ov[0]), .out_ready(ordy[0]), .out_array(oa0),
      .out_dup(od0), .busy(bz[0]));
   bitonic_sort_seq #(.W(4), .K(4), .SIGNED(1)) u_k4s (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_dir(g_dir),
      .in_array(g_array[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_array(oa1),
      .out_dup(od1), .busy(bz[1]));
   bitonic_sort_seq #(.W(4), .K(1), .SIGNED(0)) u_k1 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_dir(g_dir),
      .in_array(g_array[3:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_array(oa2),
      .out_dup(od2), .busy(bz[2]));
   bitonic_sort_seq #(.W(4), .K(2), .SIGNED(0)) u_k2 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_dir(g_dir),
      .in_array(g_array[7:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_array(oa3),
      .out_dup(od3), .busy(bz[3]));
   bitonic_sort_seq #(.W(4), .K(4), .SIGNED(0)) u_k4u (
      .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .in_dir(g_dir),
      .in_array(g_array[15:0]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_array(oa4),
      .out_dup(od4), .busy(bz[4]));

   always_comb begin
      g_in_ready  = ir[sel];
      g_out_valid = ov[sel];
      g_busy      = bz[sel];
      g_out_array = '0;
      g_out_dup   = '0;
      case (sel)
         0: begin g_out_array = oa0;         g_out_dup = od0;        end
         1: begin g_out_array = {16'd0, oa1}; g_out_dup = {4'd0, od1}; end
         2: begin g_out_array = {28'd0, oa2}; g_out_dup = {7'd0, od2}; end
         3: begin g_out_array = {24'd0, oa3}; g_out_dup = {6'd0, od3}; end
         default: begin g_out_array = {16'd0, oa4}; g_out_dup = {4'd0, od4}; end
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (sel %0d): got %h expected %h", tag, sel, got, exp);
      end
   endtask

   function automatic int n_of(input int s);
      case (s)
         0: return 8;
         2: return 1;
         3: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int stages_of(input int n);
      int l = $clog2(n);
      return l * (l + 1) / 2;
   endfunction

   function automatic logic [31:0] mask_of(input int n);
      if (n == 8) return 32'hFFFF_FFFF;
      return (32'd1 << (n * 4)) - 32'd1;
   endfunction

   // Reference: read keys as integers, insertion sort ascending, reverse for descending.
   function automatic logic [31:0] model_sort(input logic [31:0] a, input int n,
                                              input bit sgn, input bit up);
      int vals[8];
      int t;
      logic [31:0] r = '0;
      logic [3:0]  k;
      for (int i = 0; i < n; i++) begin
         k = a[i*4 +: 4];
         vals[i] = sgn ? int'($signed(k)) : int'(k);
      end
      for (int i = 1; i < n; i++)
         for (int j = i; j > 0 && vals[j-1] > vals[j]; j--) begin
            t = vals[j]; vals[j] = vals[j-1]; vals[j-1] = t;
         end
      for (int i = 0; i < n; i++) begin
         t = up ? vals[i] : vals[n-1-i];
         r[i*4 +: 4] = t[3:0];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_dup(input logic [31:0] x, input int n);
      logic [31:0] d = '0;
      for (int i = 1; i < n; i++) d[i] = (x[i*4 +: 4] == x[(i-1)*4 +: 4]);
      return d;
   endfunction

   task automatic drive_and_accept(input logic [31:0] a, input logic d);
      int guard = 0;
      @(negedge clk);
      g_valid = 1'b1; g_array = a; g_dir = d;
      while (!g_in_ready && guard < 100) begin @(negedge clk); guard++; end
      check("in_ready_wait", {31'd0, g_in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      g_valid = 1'b0;
      check("busy_after_accept", {31'd0, g_busy}, {31'd0, stages_of(n_of(sel)) > 0});
   endtask

   task automatic wait_result();
      int lat = 0;
      while (!g_out_valid && lat < 200) begin @(negedge clk); lat++; end
      check("latency", lat, stages_of(n_of(sel)));
   endtask

   task automatic receive(input logic [31:0] exp, input int hold, input bit keep,
                          input logic [31:0] junk, input logic jd);
      logic [31:0] ed = model_dup(exp, n_of(sel));
      if (hold > 0 || keep) begin g_valid = 1'b1; g_array = junk; g_dir = jd; end
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", {31'd0, g_out_valid}, 32'd1);
         check("hold_array", g_out_array, exp);
         check("hold_in_ready", {31'd0, g_in_ready}, 32'd0);
         @(negedge clk);
      end
      check("out_array", g_out_array, exp);
      check("out_dup", {24'd0, g_out_dup}, ed);
      g_ready = 1'b1;
      @(negedge clk);
      g_ready = 1'b0;
      check("release_valid", {31'd0, g_out_valid}, 32'd0);
      check("release_in_ready", {31'd0, g_in_ready}, 32'd1);
      check("release_busy", {31'd0, g_busy}, 32'd0);
      if (!keep) g_valid = 1'b0;
   endtask

   task automatic run_job(input logic [31:0] a_raw, input logic d, input int hold);
      int          n = n_of(sel);
      logic [31:0] a = a_raw & mask_of(n);
      drive_and_accept(a, d);
      wait_result();
      receive(model_sort(a, n, sel == 1, d), hold, 1'b0, $urandom & mask_of(n), 1'($urandom));
   endtask

   function automatic logic [31:0] rand_keys(input bit dupish);
      logic [31:0] a;
      for (int i = 0; i < 8; i++)
         a[i*4 +: 4] = dupish ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      return a;
   endfunction

   initial begin
      logic [31:0] j;
      bit          quiet;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 5; s++) begin
         sel = s;
         #0;
         check("rst_in_ready", {31'd0, g_in_ready}, 32'd1);
         check("rst_out_valid", {31'd0, g_out_valid}, 32'd0);
         check("rst_busy", {31'd0, g_busy}, 32'd0);
         check("rst_out_array", g_out_array, 32'd0);
         check("rst_out_dup", {24'd0, g_out_dup}, 32'd0);
      end

      // K=8 directed data 3,7,1,7,0,5,2,7 both directions
      sel = 0;
      run_job(32'h7250_7173, 1'b1, 0);
      run_job(32'h7250_7173, 1'b0, 0);

      // Back-pressure with in_valid held through DONE and the handshake cycle
      j = rand_keys(1'b0);
      drive_and_accept(32'h7250_7173, 1'b1);
      wait_result();
      receive(model_sort(32'h7250_7173, 8, 1'b0, 1'b1), 10, 1'b1, j, 1'b0);
      check("no_accept_on_release", {31'd0, g_busy}, 32'd0);
      @(negedge clk);
      g_valid = 1'b0;
      check("accept_after_idle", {31'd0, g_busy}, 32'd1);
      wait_result();
      receive(model_sort(j, 8, 1'b0, 1'b0), 0, 1'b0, 32'd0, 1'b0);

      // Reset on the third SORT cycle
      drive_and_accept(rand_keys(1'b0), 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", {31'd0, g_out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, g_in_ready}, 32'd1);
      check("abort_busy", {31'd0, g_busy}, 32'd0);
      check("abort_data", g_out_array, 32'd0);
      quiet = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (g_out_valid) quiet = 1'b0;
         @(negedge clk);
      end
      check("abort_no_output", {31'd0, quiet}, 32'd1);
      run_job(32'h7250_7173, 1'b1, 0);

      // Signed and unsigned K=4 with F,2,8,0
      sel = 1;
      run_job(32'h0000_082F, 1'b1, 0);
      sel = 4;
      run_job(32'h0000_082F, 1'b1, 0);

      // Degenerate sizes
      sel = 2;
      run_job(32'h0000_0005, 1'b1, 0);
      run_job(32'h0000_000C, 1'b0, 2);
      sel = 3;
      run_job(32'h0000_0099, 1'b1, 0);
      run_job(32'h0000_0036, 1'b0, 0);

      // Random jobs across every instance
      for (int t = 0; t < 60; t++) begin
         sel = $urandom_range(0, 4);
         run_job(rand_keys(1'($urandom_range(0, 1))), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
